// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read, threshold flags, occupancy count
// and sticky overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through mode.
module fifo_sync #(
    parameter int  DSIZE     = 8,
    parameter int  ASIZE     = 4,
    localparam int DEPTH     = 1 << ASIZE,
    parameter int  AFULL_TH  = DEPTH - 2,
    parameter int  AEMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE_C    = (ASIZE+1)'(1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr_q;
    logic [ASIZE:0]   rptr_q;
    logic [ASIZE:0]   count_q;
    logic [ASIZE:0]   count_nxt;
    logic             wfull_q;
    logic             rempty_q;
    logic             afull_q;
    logic             aempty_q;
    logic             ovf_q;
    logic             udf_q;
    logic [DSIZE-1:0] rdata_q;
    logic             w_acc;
    logic             r_acc;
    logic             ram_rd;

    // Full wins over a same-cycle read: a write while full is always dropped.
    assign w_acc = winc & ~wfull_q;
    assign r_acc = rinc & ~rempty_q;

    always_comb begin
        count_nxt = count_q;
        if (w_acc && !r_acc) begin
            count_nxt = count_q + ONE_C;
        end else if (r_acc && !w_acc) begin
            count_nxt = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (w_acc) begin
                wptr_q <= wptr_q + ONE_C;
            end
            if (ram_rd) begin
                rptr_q <= rptr_q + ONE_C;
            end
            count_q  <= count_nxt;
            wfull_q  <= (count_nxt == DEPTH_C);
            afull_q  <= (count_nxt >= AFULL_C);
            aempty_q <= (count_nxt <= AEMPTY_C);
            ovf_q    <= ovf_q | (winc & wfull_q);
            udf_q    <= udf_q | (rinc & rempty_q);
        end
    end

`ifdef FIFO_FWFT_EN
    // The output register holds the head word and is part of the occupancy,
    // so the array itself never holds more than DEPTH minus that one word.
    logic out_vld_q;
    logic ram_empty;

    assign ram_empty = (wptr_q == rptr_q);
    assign ram_rd    = ~ram_empty & (~out_vld_q | r_acc);
    assign rempty_q  = ~out_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            rdata_q   <= '0;
        end else if (ram_rd) begin
            out_vld_q <= 1'b1;
            rdata_q   <= mem[rptr_q[ASIZE-1:0]];
        end else if (r_acc) begin
            out_vld_q <= 1'b0;
        end
    end
`else
    // Array read is registered into a stage, then presented one edge later.
    logic             rd_pend_q;
    logic [DSIZE-1:0] rd_stage_q;

    assign ram_rd = r_acc;

    always_ff @(posedge clk) begin
        if (r_acc) begin
            rd_stage_q <= mem[rptr_q[ASIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
            rempty_q  <= 1'b1;
        end else begin
            rd_pend_q <= r_acc;
            rempty_q  <= (count_nxt == '0);
            if (rd_pend_q) begin
                rdata_q <= rd_stage_q;
            end
        end
    end
`endif

    assign wfull         = wfull_q;
    assign walmost_full  = afull_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = aempty_q;
    assign rdata         = rdata_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync in standard (registered-read) mode,
// DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=1.
module tb_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       wfull;
    logic       walmost_full;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_sync #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .rinc         (rinc),
        .rdata        (rdata),
        .rempty       (rempty),
        .ralmost_empty(ralmost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; winc = 1'b1; rinc = 1'b1; wdata = 8'h33;
        tick();
        tick();
        tests_run++;
        if (rempty !== 1'b1 || wfull !== 1'b0 || count !== 5'd0 || rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_core: rempty=%b wfull=%b count=%0d rdata=%h, want 1 0 0 00",
                     rempty, wfull, count, rdata);
        end
        tests_run++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || walmost_full !== 1'b0 || ralmost_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_flags: ovf=%b udf=%b afull=%b aempty=%b, want 0 0 0 1",
                     overflow, underflow, walmost_full, ralmost_empty);
        end
        rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
        tick();
        tests_run++;
        if (rempty !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: rempty=%b count=%0d, want 1 0", rempty, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1; wdata = 8'(i);
            tick();
            tests_run++;
            if (count !== 5'(i + 1) || walmost_full !== (i + 1 >= 14) || wfull !== (i == 15)
                || rempty !== 1'b0) begin
                tests_failed++;
                $display("FAIL fill_%0d: count=%0d afull=%b wfull=%b rempty=%b, want %0d %b %b 0",
                         i, count, walmost_full, wfull, rempty, i + 1, (i + 1 >= 14), (i == 15));
            end
        end
        wdata = 8'hAA;
        tick();
        winc = 1'b0;
        tests_run++;
        if (count !== 5'd16 || wfull !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_overflow: count=%0d wfull=%b ovf=%b udf=%b, want 16 1 1 0",
                     count, wfull, overflow, underflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rinc = 1'b1;
            tick();
            tests_run++;
            if (count !== 5'(15 - i) || rempty !== (i == 15) || ralmost_empty !== (15 - i <= 1)
                || wfull !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_flags_%0d: count=%0d rempty=%b aempty=%b wfull=%b, want %0d %b %b 0",
                         i, count, rempty, ralmost_empty, wfull, 15 - i, (i == 15), (15 - i <= 1));
            end
            if (i > 0) begin
                tests_run++;
                if (rdata !== 8'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL drain_data_%0d: rdata=%h, want %h", i, rdata, 8'(i - 1));
                end
            end
        end
        tick();
        tests_run++;
        if (rdata !== 8'h0F || underflow !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL drain_underflow: rdata=%h udf=%b count=%0d, want 0f 1 0", rdata, underflow, count);
        end
        rinc = 1'b0;
        tick();
        tests_run++;
        if (rdata !== 8'h0F || underflow !== 1'b1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_hold: rdata=%h udf=%b ovf=%b, want 0f 1 1", rdata, underflow, overflow);
        end
    endtask

    function automatic logic [7:0] sim_exp(int k);
        return (k < 8) ? 8'(8'h10 + k) : 8'(8'h20 + k - 8);
    endfunction

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1; wdata = 8'(8'h10 + i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h20 + i);
            tick();
            tests_run++;
            if (count !== 5'd8 || rempty !== 1'b0 || wfull !== 1'b0) begin
                tests_failed++;
                $display("FAIL sim_count_%0d: count=%0d rempty=%b wfull=%b, want 8 0 0", i, count, rempty, wfull);
            end
            if (i > 0) begin
                tests_run++;
                if (rdata !== sim_exp(i - 1)) begin
                    tests_failed++;
                    $display("FAIL sim_data_%0d: rdata=%h, want %h", i, rdata, sim_exp(i - 1));
                end
            end
        end
        winc = 1'b0;
        for (int j = 0; j < 8; j++) begin
            rinc = 1'b1;
            tick();
            tests_run++;
            if (rdata !== sim_exp(19 + j)) begin
                tests_failed++;
                $display("FAIL sim_tail_%0d: rdata=%h, want %h", j, rdata, sim_exp(19 + j));
            end
        end
        rinc = 1'b0;
        tick();
        tests_run++;
        if (rdata !== 8'h33 || rempty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL sim_end: rdata=%h rempty=%b count=%0d ovf=%b udf=%b, want 33 1 0 0 0",
                     rdata, rempty, count, overflow, underflow);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1; wdata = 8'(8'h40 + i);
            tick();
        end
        winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
        tick();
        tests_run++;
        if (count !== 5'd15 || wfull !== 1'b0 || overflow !== 1'b1 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_rw: count=%0d wfull=%b ovf=%b udf=%b, want 15 0 1 0",
                     count, wfull, overflow, underflow);
        end
        winc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            tests_run++;
            if (rdata !== 8'(8'h40 + i)) begin
                tests_failed++;
                $display("FAIL full_rw_data_%0d: rdata=%h, want %h", i, rdata, 8'(8'h40 + i));
            end
        end
        rinc = 1'b0;
        tick();
        tests_run++;
        if (rdata !== 8'h4F || rempty !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL full_rw_end: rdata=%h rempty=%b count=%0d, want 4f 1 0", rdata, rempty, count);
        end
    endtask

    initial begin
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_full_rw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
